// File: rtl/rtc_master.sv
// Host-side initiator for the 3-wire PRAM/RTC link: drives chip select and the
// serial clock, shifts a command (and write byte) out MSB first, reads 8 bits back.
module rtc_master #(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] cmd,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       rtc_cs_n,
   output logic       rtc_ck,
   output logic       rtc_dat_o,
   output logic       rtc_dat_oe,
   input  logic       rtc_dat_i,
   output logic [3:0] dbg_state
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_SETUP, ST_CMD_LO, ST_CMD_HI, ST_WR_LO, ST_WR_HI,
      ST_RD_LO, ST_RD_HI, ST_HOLD, ST_END, ST_FIN
   } state_t;

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   state_t     state;
   logic [7:0] cnt;
   logic [2:0] bit_n;
   logic       rd_q;
   logic [7:0] tx_sr;
   logic [7:0] wdata_q;
   logic [7:0] rx_sr;
   logic       phase_end;

   assign phase_end = (cnt == LAST);
   assign dbg_state = 4'(state);

   // Handshake: start is a one-cycle request taken only while busy=0 (the done
   // cycle included); requests seen while busy=1 are dropped, never queued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= 8'd0;
         bit_n      <= 3'd0;
         rd_q       <= 1'b0;
         tx_sr      <= 8'd0;
         wdata_q    <= 8'd0;
         rx_sr      <= 8'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rdata      <= 8'd0;
         rtc_cs_n   <= 1'b1;
         rtc_ck     <= 1'b1;
         rtc_dat_o  <= 1'b1;
         rtc_dat_oe <= 1'b0;
      end else begin
         done <= 1'b0;
         cnt  <= (phase_end || state == ST_IDLE || state == ST_FIN) ? 8'd0 : cnt + 8'd1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  rd_q     <= cmd[7];
                  tx_sr    <= cmd;
                  wdata_q  <= wdata;
                  bit_n    <= 3'd0;
                  busy     <= 1'b1;
                  rtc_cs_n <= 1'b0;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (phase_end) begin
                  rtc_ck     <= 1'b0;
                  rtc_dat_oe <= 1'b1;
                  rtc_dat_o  <= tx_sr[7];
                  tx_sr      <= {tx_sr[6:0], 1'b0};
                  state      <= ST_CMD_LO;
               end
            end
            ST_CMD_LO: begin
               if (phase_end) begin
                  rtc_ck <= 1'b1;
                  state  <= ST_CMD_HI;
               end
            end
            ST_CMD_HI: begin
               if (phase_end) begin
                  rtc_ck <= 1'b0;
                  if (bit_n != 3'd7) begin
                     bit_n     <= bit_n + 3'd1;
                     rtc_dat_o <= tx_sr[7];
                     tx_sr     <= {tx_sr[6:0], 1'b0};
                     state     <= ST_CMD_LO;
                  end else if (!rd_q) begin
                     bit_n     <= 3'd0;
                     rtc_dat_o <= wdata_q[7];
                     tx_sr     <= {wdata_q[6:0], 1'b0};
                     state     <= ST_WR_LO;
                  end else begin
                     // Line is released on the same edge the clock falls.
                     bit_n      <= 3'd0;
                     rtc_dat_oe <= 1'b0;
                     state      <= ST_RD_LO;
                  end
               end
            end
            ST_WR_LO: begin
               if (phase_end) begin
                  rtc_ck <= 1'b1;
                  state  <= ST_WR_HI;
               end
            end
            ST_WR_HI: begin
               if (phase_end) begin
                  if (bit_n != 3'd7) begin
                     bit_n     <= bit_n + 3'd1;
                     rtc_ck    <= 1'b0;
                     rtc_dat_o <= tx_sr[7];
                     tx_sr     <= {tx_sr[6:0], 1'b0};
                     state     <= ST_WR_LO;
                  end else begin
                     rtc_dat_oe <= 1'b0;
                     state      <= ST_HOLD;
                  end
               end
            end
            ST_RD_LO: begin
               // Sample late in the low phase, after the responder has updated.
               if (phase_end) begin
                  rx_sr  <= {rx_sr[6:0], rtc_dat_i};
                  rtc_ck <= 1'b1;
                  state  <= ST_RD_HI;
               end
            end
            ST_RD_HI: begin
               if (phase_end) begin
                  if (bit_n != 3'd7) begin
                     bit_n  <= bit_n + 3'd1;
                     rtc_ck <= 1'b0;
                     state  <= ST_RD_LO;
                  end else begin
                     state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (phase_end) begin
                  if (rd_q) rdata <= rx_sr;
                  rtc_cs_n  <= 1'b1;
                  rtc_dat_o <= 1'b1;
                  state     <= ST_END;
               end
            end
            ST_END: begin
               if (phase_end) state <= ST_FIN;
            end
            ST_FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_master.sv
// Bench for rtc_master: two instances (CLK_DIV 4 and 8) talking to a PRAM/RTC
// responder; a memory-level model predicts every transaction's outcome.
module tb_rtc_master;

   typedef struct packed {
      logic        rd;
      logic [7:0]  rdata;
      logic [15:0] bits;
      logic [31:0] t0;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       start_s[2];
   logic [7:0] cmd_s[2];
   logic [7:0] wdata_s[2];
   logic       busy_s[2];
   logic       done_s[2];
   logic [7:0] rdata_s[2];
   logic       cs_n_s[2];
   logic       ck_s[2];
   logic       dat_o_s[2];
   logic       oe_s[2];
   logic       dat_i_s[2];
   logic [3:0] dbg_s[2];

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc = 0;

   // responder state
   logic        cs_prev[2];
   logic        ck_prev[2];
   int          rise_cnt[2];
   int          fall_cnt[2];
   logic [15:0] cap[2];
   logic [15:0] oe_rise[2];
   logic [15:0] oe_fall[2];
   logic        rd_txn[2];
   logic [7:0]  rbyte[2];
   logic [7:0]  rmem[2][32];

   // reference model and scoreboard
   logic [7:0]  mdl_mem[2][32];
   logic [7:0]  mdl_rdata[2];
   exp_t        exp_q0[$];
   exp_t        exp_q1[$];

   rtc_master #(.CLK_DIV(4)) u_div4 (
      .clk(clk), .reset(reset), .start(start_s[0]), .cmd(cmd_s[0]), .wdata(wdata_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .rdata(rdata_s[0]), .rtc_cs_n(cs_n_s[0]),
      .rtc_ck(ck_s[0]), .rtc_dat_o(dat_o_s[0]), .rtc_dat_oe(oe_s[0]),
      .rtc_dat_i(dat_i_s[0]), .dbg_state(dbg_s[0])
   );

   rtc_master #(.CLK_DIV(8)) u_div8 (
      .clk(clk), .reset(reset), .start(start_s[1]), .cmd(cmd_s[1]), .wdata(wdata_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .rdata(rdata_s[1]), .rtc_cs_n(cs_n_s[1]),
      .rtc_ck(ck_s[1]), .rtc_dat_o(dat_o_s[1]), .rtc_dat_oe(oe_s[1]),
      .rtc_dat_i(dat_i_s[1]), .dbg_state(dbg_s[1])
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int div_of(input int k);
      return (k == 0) ? 4 : 8;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // PRAM/RTC responder: samples on ck rising edges, drives read data after falling edges.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            cs_prev[k]  = 1'b1;
            ck_prev[k]  = 1'b1;
            dat_i_s[k]  = 1'b1;
            rise_cnt[k] = 0;
            fall_cnt[k] = 0;
            rd_txn[k]   = 1'b0;
         end else begin
            if (!cs_n_s[k] && cs_prev[k]) begin
               rise_cnt[k] = 0;
               fall_cnt[k] = 0;
               cap[k]      = 16'h0;
               oe_rise[k]  = 16'h0;
               oe_fall[k]  = 16'h0;
               rd_txn[k]   = 1'b0;
               dat_i_s[k]  = 1'b1;
            end
            if (!cs_n_s[k]) begin
               if (ck_s[k] && !ck_prev[k]) begin
                  cap[k]     = {cap[k][14:0], dat_o_s[k]};
                  oe_rise[k] = {oe_rise[k][14:0], oe_s[k]};
                  rise_cnt[k]++;
                  if (rise_cnt[k] == 8) begin
                     rd_txn[k] = cap[k][7];
                     rbyte[k]  = rmem[k][cap[k][6:2]];
                  end
                  if (rise_cnt[k] == 16 && !rd_txn[k]) rmem[k][cap[k][14:10]] = cap[k][7:0];
               end
               if (!ck_s[k] && ck_prev[k]) begin
                  oe_fall[k] = {oe_fall[k][14:0], oe_s[k]};
                  fall_cnt[k]++;
                  if (rd_txn[k] && fall_cnt[k] >= 9 && fall_cnt[k] <= 16)
                     dat_i_s[k] = rbyte[k][16 - fall_cnt[k]];
               end
            end
            cs_prev[k] = cs_n_s[k];
            ck_prev[k] = ck_s[k];
         end
      end
   end

   // scoreboard monitor: one expected entry per done pulse
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset && done_s[k]) begin
            exp_t e;
            int   qs;
            qs = (k == 0) ? exp_q0.size() : exp_q1.size();
            if (qs == 0) begin
               check("spurious_done", 32'(done_s[k]), 32'd0);
            end else begin
               if (k == 0) e = exp_q0.pop_front();
               else        e = exp_q1.pop_front();
               check("latency", cyc - e.t0, 32'(35 * div_of(k) + 1));
               check("rdata", 32'(rdata_s[k]), 32'(e.rdata));
               check("cmd_bits", 32'(cap[k][15:8]), 32'(e.bits[15:8]));
               if (!e.rd) check("wdata_bits", 32'(cap[k][7:0]), 32'(e.bits[7:0]));
               check("ck_rises", 32'(rise_cnt[k]), 32'd16);
               check("oe_at_rise", 32'(oe_rise[k]), e.rd ? 32'h0000ff00 : 32'h0000ffff);
               check("oe_at_fall", 32'(oe_fall[k]), e.rd ? 32'h0000ff00 : 32'h0000ffff);
               check("busy_at_done", 32'(busy_s[k]), 32'd0);
            end
         end
      end
   end

   // driver tasks (called at a negedge)
   task automatic pulse_start(input int k, input logic [7:0] c, input logic [7:0] w);
      start_s[k] = 1'b1;
      cmd_s[k]   = c;
      wdata_s[k] = w;
      @(negedge clk);
      start_s[k] = 1'b0;
   endtask

   task automatic issue(input int k, input logic [7:0] c, input logic [7:0] w);
      exp_t e;
      pulse_start(k, c, w);
      if (c[7]) mdl_rdata[k] = mdl_mem[k][c[6:2]];
      else      mdl_mem[k][c[6:2]] = w;
      e.rd    = c[7];
      e.rdata = mdl_rdata[k];
      e.bits  = {c, c[7] ? 8'h00 : w};
      e.t0    = cyc;
      if (k == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   task automatic wait_done(input int k);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 60 * div_of(k) && !got; i++) begin
         @(negedge clk);
         if (done_s[k]) got = 1'b1;
      end
      check("done_seen", 32'(got), 32'd1);
   endtask

   task automatic wait_rise(input int k, input int n);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (rise_cnt[k] == n && !cs_n_s[k]) got = 1'b1;
      end
      check("reached_bit", 32'(got), 32'd1);
   endtask

   // Raise reset between clock edges and look at outputs before any posedge.
   task automatic do_reset_mid();
      #2 reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++)
         check("reset_outputs",
               32'({cs_n_s[k], ck_s[k], dat_o_s[k], oe_s[k], busy_s[k], done_s[k], rdata_s[k]}),
               32'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
      exp_q0.delete();
      exp_q1.delete();
      for (int k = 0; k < 2; k++) begin
         mdl_rdata[k] = 8'h00;
         start_s[k]   = 1'b0;
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle_check(input int n);
      logic bad[2];
      bad[0] = 1'b0;
      bad[1] = 1'b0;
      repeat (n) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++)
            if ({cs_n_s[k], ck_s[k], oe_s[k], busy_s[k], done_s[k], dbg_s[k]} != 9'b110000000)
               bad[k] = 1'b1;
      end
      for (int k = 0; k < 2; k++) check("idle_quiet", 32'(bad[k]), 32'd0);
   endtask

   initial begin
      logic [7:0] c;
      logic [7:0] w;
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         start_s[k]   = 1'b0;
         cmd_s[k]     = 8'h00;
         wdata_s[k]   = 8'h00;
         mdl_rdata[k] = 8'h00;
         for (int i = 0; i < 32; i++) begin
            w            = 8'($urandom);
            rmem[k][i]    = w;
            mdl_mem[k][i] = w;
         end
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset asserted mid-transaction, then a quiet idle period
      pulse_start(0, 8'h01, 8'h77);
      repeat (20) @(negedge clk);
      do_reset_mid();
      idle_check(100);

      // directed write and read at CLK_DIV=4
      issue(0, 8'h01, 8'h5A);
      wait_done(0);
      rmem[0][0]    = 8'hA5;
      mdl_mem[0][0] = 8'hA5;
      issue(0, 8'h81, 8'h00);
      wait_done(0);

      // ignored start while busy, then start on the done cycle
      issue(0, 8'h23, 8'h96);
      repeat (30) @(negedge clk);
      pulse_start(0, 8'hFF, 8'hFF);
      wait_done(0);
      check("done_cycle_idle", 32'({cs_n_s[0], busy_s[0]}), 32'b10);
      issue(0, 8'hCD, 8'h00);
      check("b2b_accept", 32'({cs_n_s[0], busy_s[0]}), 32'b01);
      wait_done(0);

      // reset at command bit 5, then a clean write
      pulse_start(0, 8'h01, 8'h3C);
      wait_rise(0, 5);
      do_reset_mid();
      issue(0, 8'h01, 8'hFF);
      wait_done(0);

      // loopback at CLK_DIV=8
      issue(1, 8'h4D, 8'h3C);
      wait_done(1);
      issue(1, 8'hCD, 8'h00);
      wait_done(1);
      issue(1, 8'h81, 8'h00);
      wait_done(1);

      // randomized traffic on both instances
      for (int k = 0; k < 2; k++) begin
         for (int t = 0; t < 12; t++) begin
            c = 8'($urandom_range(0, 255));
            w = 8'($urandom_range(0, 255));
            issue(k, c, w);
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 20)) @(negedge clk);
               pulse_start(k, 8'($urandom), 8'($urandom));
            end
            wait_done(k);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 6)) @(negedge clk);
         end
      end

      repeat (5) @(negedge clk);
      check("queue0_drained", 32'(exp_q0.size()), 32'd0);
      check("queue1_drained", 32'(exp_q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
